// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Bus initiator that moves blocks of words over the data-memory port while
//   the CPU is held off (the port is muxed to this engine while busy is high).
//   Copy mode reads a source word and writes it to the destination (2 cycles
//   per word); fill mode writes a captured pattern (1 cycle per word).
//   All outputs are registered and return to 0 outside READ/WRITE.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : transfer request, sampled only in IDLE
//   fill     : mode captured at start (0 = copy, 1 = fill)
//   srcAddr  : source byte address (copy mode), bits [1:0] ignored
//   dstAddr  : destination byte address, bits [1:0] ignored
//   len      : number of words to transfer
//   pattern  : fill value captured at start
//   memAddr  : address to data memory
//   memWrtEn : write enable to data memory (commits on the falling edge)
//   memDIn   : write data to data memory
//   memDOut  : read data from data memory
//   busy     : high while in READ or WRITE
//   done     : one-cycle pulse on completion
//   err      : one-cycle pulse on a rejected request
module mem_copy_engine #(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int LEN_BIT_WIDTH  = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      fill,
  input  logic [ADDR_BIT_WIDTH-1:0] srcAddr,
  input  logic [ADDR_BIT_WIDTH-1:0] dstAddr,
  input  logic [LEN_BIT_WIDTH-1:0]  len,
  input  logic [DATA_BIT_WIDTH-1:0] pattern,
  output logic [ADDR_BIT_WIDTH-1:0] memAddr,
  output logic                      memWrtEn,
  output logic [DATA_BIT_WIDTH-1:0] memDIn,
  input  logic [DATA_BIT_WIDTH-1:0] memDOut,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int IO_BIT = 29;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t                    state_r;
  logic [ADDR_BIT_WIDTH-1:0] src_ptr_r;
  logic [ADDR_BIT_WIDTH-1:0] dst_ptr_r;
  logic [LEN_BIT_WIDTH-1:0]  len_r;
  logic [LEN_BIT_WIDTH-1:0]  count_r;
  logic                      fill_r;
  logic [DATA_BIT_WIDTH-1:0] pattern_r;
  logic [DATA_BIT_WIDTH-1:0] buf_r;

  logic [ADDR_BIT_WIDTH-1:0] src_base_s;
  logic [ADDR_BIT_WIDTH-1:0] dst_base_s;
  logic [ADDR_BIT_WIDTH-1:0] span_s;
  logic [ADDR_BIT_WIDTH-1:0] src_end_s;
  logic [ADDR_BIT_WIDTH-1:0] dst_end_s;
  logic                      io_hit_s;
  logic                      last_word_s;

  // Request decode: word-align the bases and test the ranges against the IO region.
  // A transfer spans at most 8188 bytes, far below 2^29, so a range can touch
  // bit 29 only if one of its two endpoints has bit 29 set (this also holds
  // when the range wraps past the top of the address space).
  always_comb begin
    src_base_s = {srcAddr[ADDR_BIT_WIDTH-1:2], 2'b00};
    dst_base_s = {dstAddr[ADDR_BIT_WIDTH-1:2], 2'b00};
    span_s     = ADDR_BIT_WIDTH'(len - LEN_BIT_WIDTH'(1)) << 2;
    src_end_s  = src_base_s + span_s;
    dst_end_s  = dst_base_s + span_s;
    if (len == LEN_BIT_WIDTH'(0)) begin
      // Empty range touches nothing.
      io_hit_s = 1'b0;
    end else begin
      io_hit_s = dst_base_s[IO_BIT] || dst_end_s[IO_BIT] ||
                 (!fill && (src_base_s[IO_BIT] || src_end_s[IO_BIT]));
    end
    last_word_s = ((count_r + LEN_BIT_WIDTH'(1)) == len_r);
  end

  // Transfer FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      src_ptr_r <= '0;
      dst_ptr_r <= '0;
      len_r     <= '0;
      count_r   <= '0;
      fill_r    <= 1'b0;
      pattern_r <= '0;
      buf_r     <= '0;
      memAddr   <= '0;
      memWrtEn  <= 1'b0;
      memDIn    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            src_ptr_r <= src_base_s;
            dst_ptr_r <= dst_base_s;
            len_r     <= len;
            fill_r    <= fill;
            pattern_r <= pattern;
            count_r   <= '0;
            if (io_hit_s) begin
              state_r <= ERR;
              err     <= 1'b1;
            end else if (len == LEN_BIT_WIDTH'(0)) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else if (fill) begin
              state_r  <= WRITE;
              busy     <= 1'b1;
              memAddr  <= dst_base_s;
              memWrtEn <= 1'b1;
              memDIn   <= pattern;
            end else begin
              state_r <= READ;
              busy    <= 1'b1;
              memAddr <= src_base_s;
            end
          end
        end
        READ: begin
          // Read data is valid at this edge; forward it straight to the write.
          buf_r    <= memDOut;
          state_r  <= WRITE;
          memAddr  <= dst_ptr_r;
          memWrtEn <= 1'b1;
          memDIn   <= memDOut;
        end
        WRITE: begin
          count_r   <= count_r + LEN_BIT_WIDTH'(1);
          src_ptr_r <= src_ptr_r + ADDR_BIT_WIDTH'(3'd4);
          dst_ptr_r <= dst_ptr_r + ADDR_BIT_WIDTH'(3'd4);
          if (last_word_s) begin
            state_r  <= DONE;
            busy     <= 1'b0;
            memAddr  <= '0;
            memWrtEn <= 1'b0;
            memDIn   <= '0;
            done     <= 1'b1;
          end else if (fill_r) begin
            memAddr <= dst_ptr_r + ADDR_BIT_WIDTH'(3'd4);
          end else begin
            state_r  <= READ;
            memAddr  <= src_ptr_r + ADDR_BIT_WIDTH'(3'd4);
            memWrtEn <= 1'b0;
            memDIn   <= '0;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        ERR: begin
          state_r <= IDLE;
        end
        default: begin
          state_r  <= IDLE;
          memAddr  <= '0;
          memWrtEn <= 1'b0;
          memDIn   <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed testbench for mem_copy_engine with a small word-addressed memory
// model (writes commit on the falling edge, reads are combinational).
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fill;
  logic [31:0] srcAddr;
  logic [31:0] dstAddr;
  logic [10:0] len;
  logic [31:0] pattern;
  logic [31:0] memAddr;
  logic        memWrtEn;
  logic [31:0] memDIn;
  logic [31:0] memDOut;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  mem_copy_engine #(
    .ADDR_BIT_WIDTH(32),
    .DATA_BIT_WIDTH(32),
    .LEN_BIT_WIDTH (11)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .fill    (fill),
    .srcAddr (srcAddr),
    .dstAddr (dstAddr),
    .len     (len),
    .pattern (pattern),
    .memAddr (memAddr),
    .memWrtEn(memWrtEn),
    .memDIn  (memDIn),
    .memDOut (memDOut),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem [0:1023];
  logic        tb_we  = 1'b0;
  logic        tb_clr = 1'b1;
  logic [31:0] tb_addr = 32'd0;
  logic [31:0] tb_data = 32'd0;
  int          wr_count = 0;

  always @(negedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      wr_count <= 0;
    end else begin
      if (tb_we) mem[tb_addr[11:2]] <= tb_data;
      if (memWrtEn) begin
        mem[memAddr[11:2]] <= memDIn;
        wr_count <= wr_count + 1;
      end
    end
  end

  assign memDOut = mem[memAddr[11:2]];

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  // Per-run observations
  int          done_at, err_at, busy_cnt, done_cnt, err_cnt, we_cnt, wr_base;
  logic [31:0] first_addr;
  logic [31:0] wr_q[$];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    step();
    tb_we   = 1'b0;
  endtask

  // Issue one request and observe the engine for a fixed cycle window.
  // pulse_at > 0 re-pulses start (with a different dst) at that cycle.
  task automatic run_op(input logic f, input logic [31:0] s, input logic [31:0] d,
                        input logic [10:0] l, input logic [31:0] p,
                        input int pulse_at, input int window);
    done_at = 0; err_at = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0; we_cnt = 0;
    first_addr = 32'd0;
    wr_q.delete();
    wr_base = wr_count;
    step();
    fill = f; srcAddr = s; dstAddr = d; len = l; pattern = p; start = 1'b1;
    for (int n = 1; n <= window; n++) begin
      step();
      if (n == 1) first_addr = memAddr;
      if (busy) busy_cnt++;
      if (memWrtEn) begin
        we_cnt++;
        wr_q.push_back(memAddr);
      end
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      if (err) begin
        err_cnt++;
        if (err_at == 0) err_at = n;
      end
      if (n == 1) start = 1'b0;
      if (n == pulse_at) begin
        start   = 1'b1;
        dstAddr = 32'h0000_0600;
      end
      if (n == pulse_at + 1) start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; fill = 1'b0;
    srcAddr = 32'd0; dstAddr = 32'd0; len = 11'd0; pattern = 32'd0;
    step(); step();
    tb_clr = 1'b0;

    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWrtEn", {31'd0, memWrtEn}, 32'd0);
    chk("rst_memDIn", memDIn, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);

    poke(32'h100, 32'd1);
    poke(32'h104, 32'd2);
    poke(32'h108, 32'd3);
    poke(32'h10C, 32'd4);
    rst_n = 1'b1;
    step();

    // Copy 4 words 0x100 -> 0x200
    run_op(1'b0, 32'h100, 32'h200, 11'd4, 32'd0, 0, 14);
    chk("copy_first_addr", first_addr, 32'h100);
    chk("copy_busy_cycles", busy_cnt, 32'd8);
    chk("copy_done_at", done_at, 32'd9);
    chk("copy_done_cnt", done_cnt, 32'd1);
    chk("copy_writes", we_cnt, 32'd4);
    chk("copy_dst0", peek(32'h200), 32'd1);
    chk("copy_dst1", peek(32'h204), 32'd2);
    chk("copy_dst2", peek(32'h208), 32'd3);
    chk("copy_dst3", peek(32'h20C), 32'd4);
    chk("copy_src3", peek(32'h10C), 32'd4);

    // Fill 3 words at 0x40
    run_op(1'b1, 32'h0, 32'h40, 11'd3, 32'hDEAD_BEEF, 0, 8);
    chk("fill_writes", we_cnt, 32'd3);
    chk("fill_addr0", wr_q.size() > 0 ? wr_q[0] : 32'hFFFF_FFFF, 32'h40);
    chk("fill_addr1", wr_q.size() > 1 ? wr_q[1] : 32'hFFFF_FFFF, 32'h44);
    chk("fill_addr2", wr_q.size() > 2 ? wr_q[2] : 32'hFFFF_FFFF, 32'h48);
    chk("fill_done_at", done_at, 32'd4);
    chk("fill_busy_cycles", busy_cnt, 32'd3);
    chk("fill_data2", peek(32'h48), 32'hDEAD_BEEF);

    // len == 0
    run_op(1'b0, 32'h100, 32'h300, 11'd0, 32'd0, 0, 4);
    chk("len0_done_at", done_at, 32'd1);
    chk("len0_busy", busy_cnt, 32'd0);
    chk("len0_writes", wr_count - wr_base, 32'd0);

    // Destination in IO region
    run_op(1'b0, 32'h100, 32'h2000_0000, 11'd1, 32'd0, 0, 4);
    chk("errdst_err_at", err_at, 32'd1);
    chk("errdst_err_cnt", err_cnt, 32'd1);
    chk("errdst_busy", busy_cnt, 32'd0);
    chk("errdst_done", done_cnt, 32'd0);
    chk("errdst_writes", wr_count - wr_base, 32'd0);

    // Source range crossing into bit 29
    run_op(1'b0, 32'h1FFF_FFFC, 32'h700, 11'd2, 32'd0, 0, 4);
    chk("errsrc_err_at", err_at, 32'd1);
    chk("errsrc_busy", busy_cnt, 32'd0);
    chk("errsrc_writes", wr_count - wr_base, 32'd0);

    // Reset in the middle of a 10-word fill, right after the 3rd write
    wr_base = wr_count;
    step();
    fill = 1'b1; srcAddr = 32'd0; dstAddr = 32'h300; len = 11'd10;
    pattern = 32'hA5A5_0001; start = 1'b1;
    step(); start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_memWrtEn", {31'd0, memWrtEn}, 32'd0);
    chk("mid_rst_memAddr", memAddr, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    step(); step();
    chk("mid_rst_writes", wr_count - wr_base, 32'd3);
    chk("mid_rst_w2", peek(32'h308), 32'hA5A5_0001);
    chk("mid_rst_w3", peek(32'h30C), 32'd0);
    rst_n = 1'b1;
    run_op(1'b1, 32'h0, 32'h400, 11'd1, 32'h1234_5678, 0, 4);
    chk("post_rst_done_at", done_at, 32'd2);
    chk("post_rst_data", peek(32'h400), 32'h1234_5678);

    // Misaligned source, start re-pulsed during the copy
    run_op(1'b0, 32'h103, 32'h500, 11'd2, 32'd0, 2, 10);
    chk("mis_first_addr", first_addr, 32'h100);
    chk("mis_dst0", peek(32'h500), 32'd1);
    chk("mis_dst1", peek(32'h504), 32'd2);
    chk("mis_ignored_dst", peek(32'h600), 32'd0);
    chk("mis_done_cnt", done_cnt, 32'd1);
    chk("mis_done_at", done_at, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
